// File: rtl/lock_pkg.sv
// Shared constants for the combination-lock front end: button count, bit
// positions of each Basys push-button, and debounce lengths.
package lock_pkg;

    localparam int NUM_BTN = 5;

    // Bit order is {btnC, btnR, btnL, btnD, btnU}.
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    // 10 ms at 100 MHz on the board; the short value keeps simulations brief.
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int DB_CYCLES_SIM     = 4;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins, the conditioner and the lock logic.
// btnPress/btnRelease are one-cycle strobes; btnLevel is the debounced held state.
interface btn_conditioner_if;

    logic [lock_pkg::NUM_BTN-1:0] btnRaw;
    logic [lock_pkg::NUM_BTN-1:0] btnLevel;
    logic [lock_pkg::NUM_BTN-1:0] btnPress;
    logic [lock_pkg::NUM_BTN-1:0] btnRelease;
    logic                         anyPress;

    // master: board/bench side that drives pins and consumes conditioned outputs.
    modport master (
        output btnRaw,
        input  btnLevel,
        input  btnPress,
        input  btnRelease,
        input  anyPress
    );

    // slave: the conditioner itself.
    modport slave (
        input  btnRaw,
        output btnLevel,
        output btnPress,
        output btnRelease,
        output anyPress
    );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, hold-off counter and registered
// press/release strobes that rise on the same edge as the debounced level.
module btn_debounce_ch #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rstN,
    input  logic raw,
    output logic level,
    output logic pressPulse,
    output logic releasePulse
);

    localparam int               CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             st;
    logic             pressQ;
    logic             releaseQ;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             expire;

    assign mismatch = s2 ^ st;
    // The last cycle of an unbroken mismatch run commits the new level.
    assign expire   = mismatch && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            st       <= 1'b0;
            cnt      <= '0;
            pressQ   <= 1'b0;
            releaseQ <= 1'b0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            pressQ   <= expire & s2;
            releaseQ <= expire & ~s2;
            if (expire) begin
                st <= s2;
            end
            // Any agreeing cycle restarts the run, so bounces never accumulate.
            if (!mismatch || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level        = st;
    assign pressPulse   = pressQ;
    assign releasePulse = releaseQ;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions all push-buttons into clean levels and single-cycle press/release
// strobes; the lock logic only ever looks at these outputs.
module btn_conditioner
    import lock_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rstN,
    btn_conditioner_if.slave   bus
);

    logic [NUM_BTN-1:0] levelVec;
    logic [NUM_BTN-1:0] pressVec;
    logic [NUM_BTN-1:0] releaseVec;

    for (genvar i = 0; i < NUM_BTN; i++) begin : gCh
        btn_debounce_ch #(
            .DB_CYCLES (DB_CYCLES)
        ) uCh (
            .clk          (clk),
            .rstN         (rstN),
            .raw          (bus.btnRaw[i]),
            .level        (levelVec[i]),
            .pressPulse   (pressVec[i]),
            .releasePulse (releaseVec[i])
        );
    end

    assign bus.btnLevel   = levelVec;
    assign bus.btnPress   = pressVec;
    assign bus.btnRelease = releaseVec;
    // Sources are flops, so the reduction cannot glitch.
    assign bus.anyPress   = |pressVec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a 4-cycle debounce window.
module tb_btn_conditioner;
    import lock_pkg::*;

    logic clk;
    logic rstN;
    int   nChecks;
    int   nPass;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DB_CYCLES (DB_CYCLES_SIM)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) begin
            nPass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [4:0] lvl, input logic [4:0] prs,
                          input logic [4:0] rel);
        chk({tag, ".level"},   32'(bus.btnLevel),   32'(lvl));
        chk({tag, ".press"},   32'(bus.btnPress),   32'(prs));
        chk({tag, ".release"}, 32'(bus.btnRelease), 32'(rel));
        chk({tag, ".any"},     32'(bus.anyPress),   32'(|prs));
    endtask

    // Ticks through edges R..R+4 checking that nothing moves yet.
    task automatic waitQuiet(input string tag, input logic [4:0] lvl);
        for (int i = 0; i < 5; i++) begin
            tick();
            chkAll($sformatf("%s.quiet%0d", tag, i), lvl, 5'b00000, 5'b00000);
        end
    endtask

    initial begin
        nChecks    = 0;
        nPass      = 0;
        rstN       = 1'b0;
        bus.btnRaw = 5'b11111;

        // Async reset with every button held.
        #1;
        chkAll("rst0", 5'b00000, 5'b00000, 5'b00000);
        tick();
        tick();
        chkAll("rst1", 5'b00000, 5'b00000, 5'b00000);

        // Release with buttons still held: press on edge 6 after release.
        rstN = 1'b1;
        waitQuiet("heldRel", 5'b00000);
        tick();
        chkAll("heldRel.edge6", 5'b11111, 5'b11111, 5'b00000);
        tick();
        chkAll("heldRel.after", 5'b11111, 5'b00000, 5'b00000);

        // Let go of everything.
        bus.btnRaw = 5'b00000;
        waitQuiet("allOff", 5'b11111);
        tick();
        chkAll("allOff.edge", 5'b00000, 5'b00000, 5'b11111);
        tick();
        chkAll("allOff.after", 5'b00000, 5'b00000, 5'b00000);

        // Clean press on btnU.
        bus.btnRaw[BTN_U] = 1'b1;
        waitQuiet("pressU", 5'b00000);
        tick();
        chkAll("pressU.edge", 5'b00001, 5'b00001, 5'b00000);
        tick();
        chkAll("pressU.after", 5'b00001, 5'b00000, 5'b00000);

        // Bouncing btnL: 3 high / 2 low twice, then a firm press.
        for (int b = 0; b < 2; b++) begin
            bus.btnRaw[BTN_L] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chkAll($sformatf("bounce%0d.hi%0d", b, i), 5'b00001, 5'b00000, 5'b00000);
            end
            bus.btnRaw[BTN_L] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                tick();
                chkAll($sformatf("bounce%0d.lo%0d", b, i), 5'b00001, 5'b00000, 5'b00000);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chkAll($sformatf("bounce.settle%0d", i), 5'b00001, 5'b00000, 5'b00000);
        end
        bus.btnRaw[BTN_L] = 1'b1;
        waitQuiet("pressL", 5'b00001);
        tick();
        chkAll("pressL.edge", 5'b00101, 5'b00100, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chkAll($sformatf("pressL.after%0d", i), 5'b00101, 5'b00000, 5'b00000);
        end

        // btnC held, then released.
        bus.btnRaw[BTN_C] = 1'b1;
        waitQuiet("holdC", 5'b00101);
        tick();
        chkAll("holdC.edge", 5'b10101, 5'b10000, 5'b00000);
        tick();
        tick();
        chkAll("holdC.held", 5'b10101, 5'b00000, 5'b00000);
        bus.btnRaw[BTN_C] = 1'b0;
        waitQuiet("relC", 5'b10101);
        tick();
        chkAll("relC.edge", 5'b00101, 5'b00000, 5'b10000);
        tick();
        chkAll("relC.after", 5'b00101, 5'b00000, 5'b00000);

        // btnD and btnR together, then btnR released on its own.
        bus.btnRaw = 5'b01111;
        waitQuiet("pressDR", 5'b00101);
        tick();
        chkAll("pressDR.edge", 5'b01111, 5'b01010, 5'b00000);
        tick();
        chkAll("pressDR.after", 5'b01111, 5'b00000, 5'b00000);
        tick();
        bus.btnRaw[BTN_R] = 1'b0;
        waitQuiet("relR", 5'b01111);
        tick();
        chkAll("relR.edge", 5'b00111, 5'b00000, 5'b01000);
        tick();
        chkAll("relR.after", 5'b00111, 5'b00000, 5'b00000);

        // Reset two counts into a btnC press run.
        bus.btnRaw[BTN_C] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chkAll($sformatf("midRun%0d", i), 5'b00111, 5'b00000, 5'b00000);
        end
        rstN = 1'b0;
        #1;
        chkAll("midRst.async", 5'b00000, 5'b00000, 5'b00000);
        tick();
        tick();
        chkAll("midRst.hold", 5'b00000, 5'b00000, 5'b00000);
        rstN = 1'b1;
        waitQuiet("midRel", 5'b00000);
        tick();
        chkAll("midRel.edge6", 5'b10111, 5'b10111, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chkAll($sformatf("midRel.after%0d", i), 5'b10111, 5'b00000, 5'b00000);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
